realign_runtime: RTL and testbench

REALIGN_RUNTIME -- requirements
Module: realign_runtime

---
 rtl/realign_runtime.sv | 181 ++++++++++++++++++
 tb/tb_realign_runtime.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/realign_runtime.sv
// Packet realigner: strips a per-packet count of leading bytes and
// repacks the remaining bytes into full-width output beats.
module realign_runtime #(
  parameter int DATA_W     = 512,
  parameter int BUF_STAGES = 4,
  localparam int B     = DATA_W / 8,
  localparam int PAD_W = $clog2(B)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              src_realign_data_val,
  input  logic [DATA_W-1:0] src_realign_data,
  input  logic [PAD_W-1:0]  src_realign_data_padbytes,
  input  logic              src_realign_data_last,
  input  logic [PAD_W-1:0]  src_realign_shift_bytes,
  output logic              realign_src_data_rdy,
  output logic              realign_dst_data_val,
  output logic [DATA_W-1:0] realign_dst_data,
  output logic [PAD_W-1:0]  realign_dst_data_padbytes,
  output logic              realign_dst_data_last,
  input  logic              dst_realign_data_rdy,
  output logic [DATA_W-1:0] realign_dst_removed_data,
  output logic              realign_dst_removed_val
);

  localparam int PTR_W = $clog2(BUF_STAGES);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PAD_W:0]   B_L  = (PAD_W + 1)'(B);
  localparam logic [PAD_W+3:0] DW_L = (PAD_W + 4)'(DATA_W);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_STAGES);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
    logic [PAD_W-1:0]  pad;
    logic              first;
    logic [PAD_W-1:0]  s;
  } entry_t;

  typedef enum logic {READING, DRAIN} state_t;

  entry_t            mem_q [BUF_STAGES];
  entry_t            in_e;
  entry_t            head;
  logic [PTR_W-1:0]  wr_q, wr_d;
  logic [PTR_W-1:0]  rd_q, rd_d;
  logic [PTR_W-1:0]  nptr;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  state_t            state_q, state_d;
  logic              first_q, first_d;
  logic              rdy_q, rdy_d;
  logic [PAD_W-1:0]  pkt_s_q, pkt_s_d;
  logic [DATA_W-1:0] removed_q, removed_d;
  logic [DATA_W-1:0] removed_c;
  logic [DATA_W-1:0] nxt_data;
  logic              nxt_last;
  logic [PAD_W-1:0]  nxt_pad;
  logic [PAD_W:0]    nxt_bytes;
  logic [PAD_W+2:0]  sh;
  logic [PAD_W+3:0]  rsh;
  logic              push, pop, hs, drain_go;

  assign nptr     = rd_q + PTR_W'(1);
  assign head     = mem_q[rd_q];
  assign nxt_last = mem_q[nptr].last;
  assign nxt_pad  = mem_q[nptr].pad;
  assign nxt_data = head.last ? {DATA_W{1'b0}}
                              : mem_q[nptr].data;

  assign realign_src_data_rdy = rdy_q && (cnt_q != FULL);
  assign push = src_realign_data_val && realign_src_data_rdy;
  assign hs   = realign_dst_data_val && dst_realign_data_rdy;
  assign pop  = hs || (state_q == DRAIN);

  always_comb begin
    in_e.data  = src_realign_data;
    in_e.last  = src_realign_data_last;
    in_e.pad   = src_realign_data_padbytes;
    in_e.first = first_q;
    in_e.s     = first_q ? src_realign_shift_bytes : pkt_s_q;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= in_e;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      first_q   <= 1'b1;
      rdy_q     <= 1'b0;
      pkt_s_q   <= '0;
      removed_q <= '0;
    end else begin
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      first_q   <= first_d;
      rdy_q     <= rdy_d;
      pkt_s_q   <= pkt_s_d;
      removed_q <= removed_d;
    end
  end

  always_comb begin
    wr_d      = wr_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    first_d   = first_q;
    rdy_d     = 1'b1;
    pkt_s_d   = pkt_s_q;
    removed_d = removed_q;
    if (push) begin
      wr_d    = wr_q + PTR_W'(1);
      first_d = src_realign_data_last;
      if (first_q) pkt_s_d = src_realign_shift_bytes;
    end
    if (pop) rd_d = nptr;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    if (realign_dst_removed_val && dst_realign_data_rdy)
      removed_d = removed_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= READING;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      READING: if (drain_go && hs) state_d = DRAIN;
      DRAIN:   state_d = READING;
    endcase
  end

  always_comb begin
    realign_dst_data_val      = 1'b0;
    realign_dst_data_last     = 1'b0;
    realign_dst_data_padbytes = '0;
    drain_go                  = 1'b0;
    nxt_bytes                 = B_L - {1'b0, nxt_pad};
    if (state_q == READING && cnt_q != '0) begin
      if (head.last) begin
        realign_dst_data_val      = 1'b1;
        realign_dst_data_last     = 1'b1;
        realign_dst_data_padbytes = head.pad + head.s;
      end else if (cnt_q >= CNT_W'(2)) begin
        realign_dst_data_val = 1'b1;
        if (nxt_last && nxt_bytes <= {1'b0, head.s}) begin
          // PAD_W-wide sum wraps modulo B, absorbing the -B
          realign_dst_data_last     = 1'b1;
          realign_dst_data_padbytes = nxt_pad + head.s;
          drain_go                  = 1'b1;
        end
      end
    end
  end

  assign sh  = {head.s, 3'b000};
  assign rsh = DW_L - {1'b0, sh};
  assign realign_dst_data = (head.data << sh) | (nxt_data >> rsh);

  assign removed_c = head.data & ~({DATA_W{1'b1}} >> sh);
  assign realign_dst_removed_val = realign_dst_data_val && head.first;
  assign realign_dst_removed_data =
    (state_q == READING && cnt_q != '0 && head.first) ? removed_c : removed_q;

  // a single-beat packet must be longer than its strip count
  assert property (@(posedge clk) disable iff (rst)
    !(push && first_q && src_realign_data_last &&
      (B_L - {1'b0, src_realign_data_padbytes}) <=
      {1'b0, src_realign_shift_bytes}));

endmodule

// File: tb/tb_realign_runtime.sv
// Bench for realign_runtime: packet-level byte model with directed
// cases, random back-to-back traffic and a mid-packet reset.
module tb_realign_runtime;

  localparam int DW = 128;
  localparam int B  = 16;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          src_val = 1'b0;
  logic [DW-1:0] src_data = '0;
  logic [PW-1:0] src_pad = '0;
  logic          src_last = 1'b0;
  logic [PW-1:0] src_shift = '0;
  logic          src_rdy;
  logic          dst_val;
  logic [DW-1:0] dst_data;
  logic [PW-1:0] dst_pad;
  logic          dst_last;
  logic          dst_rdy = 1'b1;
  logic [DW-1:0] rm_data;
  logic          rm_val;

  realign_runtime #(.DATA_W(DW), .BUF_STAGES(4)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .src_realign_data_val      (src_val),
    .src_realign_data          (src_data),
    .src_realign_data_padbytes (src_pad),
    .src_realign_data_last     (src_last),
    .src_realign_shift_bytes   (src_shift),
    .realign_src_data_rdy      (src_rdy),
    .realign_dst_data_val      (dst_val),
    .realign_dst_data          (dst_data),
    .realign_dst_data_padbytes (dst_pad),
    .realign_dst_data_last     (dst_last),
    .dst_realign_data_rdy      (dst_rdy),
    .realign_dst_removed_data  (rm_data),
    .realign_dst_removed_val   (rm_val)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    int            pad;
    bit            last;
    bit            first;
    logic [DW-1:0] removed;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] pkt[$];
  int         vectors = 0;
  int         errors = 0;
  int         rdy_mode = 0;
  bit         gaps = 0;

  function automatic void chk(string nm, logic [DW-1:0] act,
                              logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // expected output beats straight from the byte-stream definition
  task automatic model_packet(int s);
    int L = pkt.size();
    int olen = L - s;
    int nb = (olen + B - 1) / B;
    logic [DW-1:0] rm = '0;
    for (int i = 0; i < s; i++) rm[DW-1-8*i -: 8] = pkt[i];
    for (int k = 0; k < nb; k++) begin
      exp_t e;
      e.data = '0;
      for (int j = 0; j < B; j++)
        if (k*B + s + j < L) e.data[DW-1-8*j -: 8] = pkt[k*B + s + j];
      e.last    = (k == nb - 1);
      e.pad     = e.last ? nb*B - olen : 0;
      e.first   = (k == 0);
      e.removed = rm;
      expq.push_back(e);
    end
  endtask

  task automatic make_pkt(int L, bit rnd);
    pkt.delete();
    for (int i = 0; i < L; i++)
      pkt.push_back(rnd ? 8'($urandom) : 8'(i + 1));
  endtask

  task automatic send_beat(logic [DW-1:0] d, int pad, bit last, int s);
    int n = 0;
    bit ok = 0;
    bit r;
    src_val   = 1'b1;
    src_data  = d;
    src_pad   = PW'(pad);
    src_last  = last;
    src_shift = PW'(s);
    while (!ok && n < 1000) begin
      @(negedge clk);
      r = src_rdy;
      @(posedge clk);
      ok = r;
      n++;
    end
    if (!ok) chk("src_rdy_timeout", 0, 1);
    #1 src_val = 1'b0;
  endtask

  task automatic send_packet(int s, int maxb);
    int L = pkt.size();
    int nb = (L + B - 1) / B;
    int padl = nb*B - L;
    for (int b = 0; b < nb && b < maxb; b++) begin
      logic [DW-1:0] d;
      bit lst = (b == nb - 1);
      for (int j = 0; j < B; j++)
        d[DW-1-8*j -: 8] = (b*B + j < L) ? pkt[b*B + j] : 8'($urandom);
      send_beat(d, lst ? padl : int'($urandom % B), lst,
                (b == 0) ? s : int'($urandom % B));
      if (gaps && ($urandom % 4 == 0)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_empty();
    int n = 0;
    while (expq.size() != 0 && n < 4000) begin
      @(posedge clk);
      n++;
    end
    chk("drain_timeout", expq.size(), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("idle_val", dst_val, 0);
    @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       dst_rdy = 1'b1;
      1:       dst_rdy = 1'($urandom % 2);
      default: dst_rdy = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    exp_t e;
    logic [DW-1:0] m;
    if (!rst) begin
      if (dst_val) begin
        if (expq.size() == 0) chk("spurious_val", 1, 0);
        else begin
          e = expq[0];
          m = {DW{1'b1}} << (8 * e.pad);
          chk("data", dst_data & m, e.data & m);
          chk("pad", dst_pad, e.pad);
          chk("last", dst_last, e.last);
          chk("rm_val", rm_val, e.first);
          if (e.first) chk("rm_data", rm_data, e.removed);
          if (dst_rdy) expq.delete(0);
        end
      end else begin
        chk("rm_val_idle", rm_val, 0);
      end
    end
  end

  initial begin
    #2;
    chk("rst_val", dst_val, 0);
    chk("rst_last", dst_last, 0);
    chk("rst_pad", dst_pad, 0);
    chk("rst_rm_val", rm_val, 0);
    chk("rst_rm_data", rm_data, 0);
    chk("rst_src_rdy", src_rdy, 0);
    #10 rst = 1'b0;
    #1 chk("rdy_before_edge", src_rdy, 0);
    @(posedge clk);
    #1 chk("rdy_after_edge", src_rdy, 1);

    make_pkt(44, 0);
    model_packet(0);
    chk("m_s0_beats", expq.size(), 3);
    chk("m_s0_pad", expq[2].pad, 4);
    chk("m_s0_rm", expq[0].removed, 0);
    send_packet(0, 99);
    wait_empty();

    make_pkt(32, 0);
    model_packet(4);
    chk("m_s4_beats", expq.size(), 2);
    chk("m_s4_pad", expq[1].pad, 4);
    chk("m_s4_rm", expq[0].removed,
        128'h01020304_00000000_00000000_00000000);
    send_packet(4, 99);
    wait_empty();

    make_pkt(26, 0);
    model_packet(12);
    chk("m_s12_beats", expq.size(), 1);
    chk("m_s12_pad", expq[0].pad, 2);
    send_packet(12, 99);
    wait_empty();

    make_pkt(8, 0);
    model_packet(5);
    chk("m_s5_beats", expq.size(), 1);
    chk("m_s5_pad", expq[0].pad, 13);
    send_packet(5, 99);
    wait_empty();

    rdy_mode = 1;
    gaps = 1;
    for (int p = 0; p < 20; p++) begin
      int s = int'($urandom % B);
      make_pkt(s + 1 + int'($urandom % (4*B)), 1);
      model_packet(s);
      send_packet(s, 99);
    end
    wait_empty();

    rdy_mode = 2;
    gaps = 0;
    @(posedge clk);
    #1;
    make_pkt(80, 1);
    model_packet(3);
    send_packet(3, 3);
    @(posedge clk);
    #1 chk("pre_rst_val", dst_val, 1);
    #2 rst = 1'b1;
    #1;
    expq.delete();
    chk("mid_rst_val", dst_val, 0);
    chk("mid_rst_rdy", src_rdy, 0);
    chk("mid_rst_rm_val", rm_val, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    rdy_mode = 0;
    @(posedge clk);
    #1 chk("rdy_after_rst", src_rdy, 1);
    make_pkt(40, 1);
    model_packet(2);
    send_packet(2, 99);
    wait_empty();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
